// File: rtl/liteic_pkg.sv
// Shared interconnect types and defaults for the liteic node arbiters.
// Holds the arbiter state encoding and the default QoS/aging sizes.
package liteic_pkg;

    localparam int IC_QOS_WIDTH    = 4;
    localparam int IC_WR_AGE_LIMIT = 7;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OFFER  = 2'd1,
        ARB_LOCKED = 2'd2
    } liteic_arb_state_t;

endpackage

// File: rtl/liteic_rr_pick.sv
// Round-robin picker: first set bit of a candidate mask at or after a pointer,
// searching upward with wrap-around. Shared by the read and write arbiters.
module liteic_rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]  i_mask,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_onehot,
    output logic [ID_WIDTH-1:0] o_id,
    output logic                o_found
);

    // Walk the slots in priority order (ptr, ptr+1, ...) and take the first candidate.
    always_comb begin
        o_onehot = '0;
        o_id     = '0;
        o_found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!o_found && i_mask[j] && (j == ((int'(i_ptr) + k) % NUM_REQ))) begin
                    o_found     = 1'b1;
                    o_onehot[j] = 1'b1;
                    o_id        = ID_WIDTH'(j);
                end else begin
                    o_found = o_found;
                end
            end
        end
    end

endmodule

// File: rtl/liteic_qos_write_arbiter.sv
// Write-path (AW/W/B) owner arbiter for one slave node: QoS priority, round-robin
// tie-break and starvation aging; the grant is held from offer until the B handshake.
module liteic_qos_write_arbiter
    import liteic_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int QOS_WIDTH = IC_QOS_WIDTH,
    parameter int AGE_LIMIT = IC_WR_AGE_LIMIT,
    parameter int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int AGE_WIDTH = $clog2(AGE_LIMIT + 1)
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*QOS_WIDTH-1:0]   qos_i,
    input  logic                           aw_hs_i,
    input  logic                           b_hs_i,
    output logic                           gnt_valid_o,
    output logic [NUM_REQ-1:0]             gnt_onehot_o,
    output logic [ID_WIDTH-1:0]            gnt_id_o,
    output logic                           locked_o,
    output logic [NUM_REQ-1:0]             aged_o
);

    liteic_arb_state_t      r_state;
    liteic_arb_state_t      w_state_nxt;
    logic                   r_gnt_valid;
    logic [NUM_REQ-1:0]     r_gnt_onehot;
    logic [ID_WIDTH-1:0]    r_gnt_id;
    logic                   r_locked;
    logic [ID_WIDTH-1:0]    r_rr_ptr;
    logic [AGE_WIDTH-1:0]   r_age [NUM_REQ];
    logic [AGE_WIDTH-1:0]   w_age_nxt [NUM_REQ];
    logic [NUM_REQ-1:0]     r_aged;

    logic [QOS_WIDTH-1:0]   w_max_qos;
    logic [NUM_REQ-1:0]     w_aged_cand;
    logic [NUM_REQ-1:0]     w_qos_cand;
    logic [NUM_REQ-1:0]     w_cand;
    logic [NUM_REQ-1:0]     w_pick_onehot;
    logic [ID_WIDTH-1:0]    w_pick_id;
    logic                   w_pick_found;
    logic                   w_load;
    logic                   w_complete;
    logic                   w_gnt_req;
    logic [ID_WIDTH-1:0]    w_rr_inc;

    // Candidate set: aged requesters win outright, otherwise the top-QoS requesters.
    always_comb begin
        w_max_qos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[i] && (qos_i[i*QOS_WIDTH +: QOS_WIDTH] > w_max_qos)) begin
                w_max_qos = qos_i[i*QOS_WIDTH +: QOS_WIDTH];
            end else begin
                w_max_qos = w_max_qos;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_aged_cand[i] = req_i[i] & r_aged[i];
            w_qos_cand[i]  = req_i[i] & (qos_i[i*QOS_WIDTH +: QOS_WIDTH] == w_max_qos);
        end
        w_cand = (|w_aged_cand) ? w_aged_cand : w_qos_cand;
    end

    liteic_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .i_mask   (w_cand),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_id     (w_pick_id),
        .o_found  (w_pick_found)
    );

    assign w_gnt_req = |(req_i & r_gnt_onehot);
    assign w_rr_inc  = (r_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : (r_gnt_id + ID_WIDTH'(1));

    // Next-state logic; b_hs_i in OFFER only counts when it arrives with aw_hs_i.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = ARB_OFFER;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_OFFER: begin
                if (aw_hs_i && b_hs_i) begin
                    w_state_nxt = ARB_IDLE;
                    w_complete  = 1'b1;
                end else if (aw_hs_i) begin
                    w_state_nxt = ARB_LOCKED;
                end else if (!w_gnt_req) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_state_nxt = ARB_OFFER;
                end
            end
            ARB_LOCKED: begin
                if (b_hs_i) begin
                    w_state_nxt = ARB_IDLE;
                    w_complete  = 1'b1;
                end else begin
                    w_state_nxt = ARB_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Age counters: idle slots clear, completions reset the winner and age the losers.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_i[i]) begin
                w_age_nxt[i] = '0;
            end else if (w_complete && r_gnt_onehot[i]) begin
                w_age_nxt[i] = '0;
            end else if (w_complete && (r_age[i] != AGE_WIDTH'(AGE_LIMIT))) begin
                w_age_nxt[i] = r_age[i] + AGE_WIDTH'(1);
            end else begin
                w_age_nxt[i] = r_age[i];
            end
        end
    end

    // State and registered grant outputs; gnt_id is kept across idle periods.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ARB_IDLE;
            r_gnt_valid  <= 1'b0;
            r_gnt_onehot <= '0;
            r_gnt_id     <= '0;
            r_locked     <= 1'b0;
            r_rr_ptr     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt_valid <= (w_state_nxt != ARB_IDLE);
            r_locked    <= (w_state_nxt == ARB_LOCKED);
            if (w_load) begin
                r_gnt_onehot <= w_pick_onehot;
                r_gnt_id     <= w_pick_id;
            end else if (w_state_nxt == ARB_IDLE) begin
                r_gnt_onehot <= '0;
            end else begin
                r_gnt_onehot <= r_gnt_onehot;
            end
            if (w_complete) begin
                r_rr_ptr <= w_rr_inc;
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end
    end

    // Age counter and aged-flag registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_age[i] <= '0;
            end
            r_aged <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_age[i]  <= w_age_nxt[i];
                r_aged[i] <= (w_age_nxt[i] == AGE_WIDTH'(AGE_LIMIT));
            end
        end
    end

    assign gnt_valid_o  = r_gnt_valid;
    assign gnt_onehot_o = r_gnt_onehot;
    assign gnt_id_o     = r_gnt_id;
    assign locked_o     = r_locked;
    assign aged_o       = r_aged;

endmodule

// File: tb/tb_liteic_qos_write_arbiter.sv
// Scoreboard bench for liteic_qos_write_arbiter: directed scenarios plus random traffic,
// each cycle's expected outputs come from a slot-level reference model.
module tb_liteic_qos_write_arbiter;

    localparam int N   = 4;
    localparam int QW  = 4;
    localparam int LIM = 3;
    localparam int IDW = 2;

    logic              clk_i   = 1'b0;
    logic              rstn_i  = 1'b0;
    logic [N-1:0]      req_i   = '0;
    logic [N*QW-1:0]   qos_i   = '0;
    logic              aw_hs_i = 1'b0;
    logic              b_hs_i  = 1'b0;
    logic              gnt_valid_o;
    logic [N-1:0]      gnt_onehot_o;
    logic [IDW-1:0]    gnt_id_o;
    logic              locked_o;
    logic [N-1:0]      aged_o;

    always #5 clk_i = ~clk_i;

    liteic_qos_write_arbiter #(
        .NUM_REQ   (N),
        .QOS_WIDTH (QW),
        .AGE_LIMIT (LIM)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .qos_i        (qos_i),
        .aw_hs_i      (aw_hs_i),
        .b_hs_i       (b_hs_i),
        .gnt_valid_o  (gnt_valid_o),
        .gnt_onehot_o (gnt_onehot_o),
        .gnt_id_o     (gnt_id_o),
        .locked_o     (locked_o),
        .aged_o       (aged_o)
    );

    typedef struct packed {
        logic           valid;
        logic [N-1:0]   onehot;
        logic [IDW-1:0] id;
        logic           locked;
        logic [N-1:0]   aged;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0 = no owner, 1 = offered, 2 = AW accepted.
    int m_state = 0;
    int m_gnt   = 0;
    int m_rr    = 0;
    int m_age [N];

    function automatic int pick_winner(input logic [N-1:0] req, input logic [N*QW-1:0] qos);
        int cand[$];
        int maxq  = -1;
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++)
            if (req[i] && m_age[i] == LIM) cand.push_back(i);
        if (cand.size() == 0) begin
            for (int i = 0; i < N; i++)
                if (req[i] && int'(qos[i*QW +: QW]) > maxq) maxq = int'(qos[i*QW +: QW]);
            for (int i = 0; i < N; i++)
                if (req[i] && int'(qos[i*QW +: QW]) == maxq) cand.push_back(i);
        end
        foreach (cand[k]) begin
            int d;
            d = (cand[k] - m_rr + N) % N;
            if (d < bestd) begin
                bestd = d;
                best  = cand[k];
            end
        end
        return best;
    endfunction

    task automatic model_step(input logic [N-1:0] req, input logic [N*QW-1:0] qos,
                              input logic aw, input logic b);
        bit   done;
        exp_t e;
        done = 1'b0;
        case (m_state)
            0: if (req != '0) begin m_gnt = pick_winner(req, qos); m_state = 1; end
            1: begin
                if (aw && b) done = 1'b1;
                else if (aw) m_state = 2;
                else if (!req[m_gnt[1:0]]) m_state = 0;
            end
            2: if (b) done = 1'b1;
            default: m_state = 0;
        endcase
        for (int i = 0; i < N; i++) begin
            if (!req[i]) m_age[i] = 0;
            else if (done) m_age[i] = (i == m_gnt) ? 0 : ((m_age[i] < LIM) ? m_age[i] + 1 : LIM);
        end
        if (done) begin
            m_rr    = (m_gnt + 1) % N;
            m_state = 0;
        end
        e.valid  = (m_state != 0);
        e.onehot = e.valid ? N'(1 << m_gnt) : '0;
        e.id     = IDW'(m_gnt);
        e.locked = (m_state == 2);
        for (int i = 0; i < N; i++) e.aged[i] = (m_age[i] == LIM);
        sb_q.push_back(e);
    endtask

    task automatic cycle(input logic [N-1:0] req, input logic [N*QW-1:0] qos,
                         input logic aw, input logic b);
        @(negedge clk_i);
        req_i   = req;
        qos_i   = qos;
        aw_hs_i = aw;
        b_hs_i  = b;
        model_step(req, qos, aw, b);
    endtask

    // One full transaction starting from IDLE: arbitration, AW accept, B complete.
    task automatic xact(input logic [N-1:0] req, input logic [N*QW-1:0] qos);
        cycle(req, qos, 1'b0, 1'b0);
        cycle(req, qos, 1'b1, 1'b0);
        cycle(req, qos, 1'b0, 1'b1);
    endtask

    task automatic reset_check();
        @(negedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        checks++;
        if (gnt_valid_o !== 1'b0 || gnt_onehot_o !== '0 || gnt_id_o !== '0 ||
            locked_o !== 1'b0 || aged_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b oh=%b id=%0d lk=%0b aged=%b want all zero",
                     gnt_valid_o, gnt_onehot_o, gnt_id_o, locked_o, aged_o);
        end
        req_i   = '0;
        aw_hs_i = 1'b0;
        b_hs_i  = 1'b0;
        @(negedge clk_i);
        rstn_i  = 1'b1;
        m_state = 0;
        m_gnt   = 0;
        m_rr    = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
    endtask

    // Monitor: compare DUT outputs after every active edge against the queued expectation.
    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk_i);
            #1;
            if (rstn_i && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = {gnt_valid_o, gnt_onehot_o, gnt_id_o, locked_o, aged_o};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL grant_outputs t=%0t got v=%0b oh=%b id=%0d lk=%0b aged=%b want v=%0b oh=%b id=%0d lk=%0b aged=%b",
                             $time, a.valid, a.onehot, a.id, a.locked, a.aged,
                             e.valid, e.onehot, e.id, e.locked, e.aged);
                end
            end
        end
    end

    initial begin : stim
        logic [N*QW-1:0] q;
        logic [N-1:0]    r;
        logic            aw;
        logic            b;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        reset_check();

        // Equal QoS, all requesting: round-robin order 0,1,2,3.
        for (int t = 0; t < 4; t++) xact(4'b1111, 16'h5555);
        cycle(4'b0000, 16'h5555, 1'b0, 1'b0);

        // QoS priority; grant held in LOCKED after the winner drops its request.
        cycle(4'b0110, 16'h0920, 1'b0, 1'b0);
        cycle(4'b0110, 16'h0920, 1'b1, 1'b0);
        cycle(4'b0010, 16'h0920, 1'b0, 1'b0);
        cycle(4'b0010, 16'h0920, 1'b0, 1'b1);
        cycle(4'b0000, 16'h0920, 1'b0, 1'b0);

        // Starvation: low-QoS slot 0 ages in and wins.
        for (int t = 0; t < 5; t++) xact(4'b1111, 16'hFFF0);
        cycle(4'b0000, 16'hFFF0, 1'b0, 1'b0);

        // Abort in OFFER, then the other requester is granted.
        cycle(4'b1010, 16'h1111, 1'b0, 1'b0);
        cycle(4'b1000, 16'h1111, 1'b0, 1'b0);
        xact(4'b1000, 16'h1111);
        cycle(4'b0000, 16'h1111, 1'b0, 1'b0);

        // Same-cycle AW and B handshakes in OFFER; B alone in OFFER is ignored.
        cycle(4'b0001, 16'h0003, 1'b0, 1'b0);
        cycle(4'b0001, 16'h0003, 1'b0, 1'b1);
        cycle(4'b0001, 16'h0003, 1'b1, 1'b1);
        cycle(4'b0000, 16'h0003, 1'b0, 1'b0);

        // Reset while LOCKED on slot 2, then the pointer restarts at slot 0.
        cycle(4'b0100, 16'h0000, 1'b0, 1'b0);
        cycle(4'b0100, 16'h0000, 1'b1, 1'b0);
        cycle(4'b0100, 16'h0000, 1'b0, 1'b0);
        reset_check();
        xact(4'b1111, 16'h7777);
        cycle(4'b0000, 16'h7777, 1'b0, 1'b0);

        // Random traffic with narrow QoS range to force ties and aging.
        r = '0;
        q = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
                if ($urandom_range(0, 19) == 0) q[i*QW +: QW] = QW'($urandom_range(0, 3));
            end
            aw = 1'b0;
            b  = 1'b0;
            if (m_state == 1) begin
                aw = ($urandom_range(0, 2) == 0);
                b  = ($urandom_range(0, 3) == 0);
            end else if (m_state == 2) begin
                b  = ($urandom_range(0, 2) == 0);
            end
            cycle(r, q, aw, b);
        end

        repeat (2) @(negedge clk_i);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/liteic_qos_write_arbiter.md
Name: liteic_qos_write_arbiter

Overview:
- Arbitration and sequencing controller for one slave node's write path (AW/W/B).
- Chooses which connected master owns the node. The decision uses AW QoS, a round-robin tie-break and starvation aging.
- Holds the grant from the offer until the B handshake completes.
- Drives the node's one-hot and binary master-select outputs, which replace the node-internal combinational priority pick and busy/select registers.

Parameters:
- NUM_REQ, 4: number of master slots connected to this node (1..32).
- QOS_WIDTH, 4: width of each AW QoS field.
- AGE_LIMIT, 7: number of lost completed arbitrations after which a requester is "aged" (1..255).
- ID_WIDTH, max(1,$clog2(NUM_REQ)): binary grant id width. Derived; do not override.
- AGE_WIDTH, $clog2(AGE_LIMIT+1): age counter width. Derived.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous assert, active-low.
- req_i  in  NUM_REQ  per-master AW valid (write request pending).
- qos_i  in  NUM_REQ*QOS_WIDTH  packed QoS; slot i is bits [i*QOS_WIDTH +: QOS_WIDTH].
- aw_hs_i  in  1  slave-side AW handshake (aw_valid & aw_ready) for the granted master.
- b_hs_i  in  1  slave-side B handshake (b_valid & b_ready).
- gnt_valid_o  out  1  a grant is active (state OFFER or LOCKED).
- gnt_onehot_o  out  NUM_REQ  one-hot grant; zero when gnt_valid_o=0.
- gnt_id_o  out  ID_WIDTH  binary grant index; holds its last value when idle.
- locked_o  out  1  the AW for the current grant has been accepted.
- aged_o  out  NUM_REQ  per-slot "age counter == AGE_LIMIT"; for debug and coverage.

Behaviour:
- Reset values (async, rstn_i=0): state=IDLE, gnt_valid_o=0, gnt_onehot_o=0, gnt_id_o=0, locked_o=0, aged_o=0, rr_ptr=0, all age counters=0. A reset mid-transaction drops the grant immediately.
- FSM states:
  - IDLE: if |req_i, register the winner and go to OFFER. All grant outputs are registered, so latency from req to gnt_valid_o is 1 cycle.
  - OFFER: if aw_hs_i, go to LOCKED; locked_o=1 next cycle.
  - OFFER abort: if req_i[gnt_id] falls without aw_hs_i, go to IDLE with no rr/age update.
  - OFFER with b_hs_i alone: ignored.
  - LOCKED: hold the grant regardless of req_i or qos_i changes. On b_hs_i, go to IDLE and perform a completion update.
- Simultaneous events:
  - aw_hs_i and b_hs_i in the same OFFER cycle: complete directly to IDLE with a completion update.
  - b_hs_i in LOCKED while other requests are pending: IDLE lasts one cycle (the re-arbitration cycle). There is no back-to-back grant in the same cycle.
- Winner selection (combinational, evaluated in IDLE):
  1. Candidate set = requesting slots with aged_o set. If that set is empty, candidate set = requesting slots whose qos equals the maximum qos among requesters.
  2. Winner = first candidate at or after rr_ptr, searching upward with wrap-around from NUM_REQ-1 to 0.
- Completion update (on the IDLE-bound transition from LOCKED or OFFER):
  - rr_ptr <= gnt_id+1, wrapping to 0 at NUM_REQ.
  - Winner's age counter <= 0.
  - Every other slot with req_i high increments its age counter, saturating at AGE_LIMIT.
- Age counter of any slot with req_i low is cleared every cycle, in any state.
- qos_i is sampled only in IDLE. Changes to qos_i during OFFER or LOCKED have no effect.
- NUM_REQ=1: the winner is always slot 0; gnt_id_o is 1 bit, always 0.

Decomposition:
- liteic_pkg additions:
  - IC_QOS_WIDTH (=4).
  - typedef enum logic [1:0] {ARB_IDLE, ARB_OFFER, ARB_LOCKED} liteic_arb_state_t.
  - IC_WR_AGE_LIMIT default constant.
- Sub-module liteic_rr_pick (NUM_REQ): inputs are a candidate mask and rr_ptr. Outputs are the one-hot and binary first-set-at-or-after-pointer, plus a found flag. It is instantiated once and is reusable by the read-path arbiter.

Test Plan (NUM_REQ=4, AGE_LIMIT=3):
- Reset mid-LOCKED (grant on slot 2): assert rstn_i low asynchronously → all outputs zero before the next edge; rr_ptr=0.
- req=4'b0110, qos1=2, qos2=9 → one cycle later gnt_onehot=4'b0100, gnt_id=2. aw_hs → locked_o=1. Drop req[2] in LOCKED → grant held. b_hs → IDLE; rr_ptr=3; age1=1.
- Equal qos=5 on all, req=4'b1111 held, 4 completions → grant order 0,1,2,3, each grant gap = 1 IDLE cycle.
- Starvation: slot0 qos=0 constant; slots1..3 qos=15, continuously requesting → after 3 lost completions aged_o[0]=1, next grant goes to slot0, then age0=0.
- Abort: grant slot1 in OFFER, deassert req[1] with no aw_hs → IDLE next cycle; rr_ptr and ages unchanged; slot3 (requesting) granted the following cycle.
- Same-cycle aw_hs_i & b_hs_i in OFFER on slot0 → IDLE next cycle, rr_ptr=1, locked_o never asserted.
